dma_rr_arbiter: RTL and testbench

- Shares the single fully-connected DMA engine among NUM_REQ requesters, e.g. input-vector, weight-row and bias loaders.
- Round-robin arbitration picks one requester at a time. The block latches that requester's address and count, launches the DMA with a one-cycle read pulse, waits for the DMA ready pulse, then returns a per-requester done pulse.
- Sits between the FC layer control logic and the DMA command inputs.

---
 rtl/dma_rr_arbiter_if.sv | 36 +++
 rtl/dma_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_dma_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_rr_arbiter_if.sv
// Requester and DMA command bundle between the FC layer control and dma_rr_arbiter.
// o_error exists only when DMA_TIMEOUT_EN is defined.
interface dma_rr_arbiter_if #(
    parameter int NUM_REQ           = 3,
    parameter int MEM_ADDRESS_WIDTH = 10
);
    logic [NUM_REQ-1:0]                   i_req;
    logic [NUM_REQ*MEM_ADDRESS_WIDTH-1:0] i_req_addr;
    logic [NUM_REQ*MEM_ADDRESS_WIDTH-1:0] i_req_count;
    logic [NUM_REQ-1:0]                   o_grant;
    logic [NUM_REQ-1:0]                   o_done;
    logic                                 o_busy;
    logic                                 o_dma_read;
    logic [MEM_ADDRESS_WIDTH-1:0]         o_dma_address;
    logic [MEM_ADDRESS_WIDTH-1:0]         o_dma_count;
    logic                                 i_dma_ready;
`ifdef DMA_TIMEOUT_EN
    logic                                 o_error;
`endif

    modport slave (
`ifdef DMA_TIMEOUT_EN
        output o_error,
`endif
        input  i_req, i_req_addr, i_req_count, i_dma_ready,
        output o_grant, o_done, o_busy, o_dma_read, o_dma_address, o_dma_count
    );

    modport master (
`ifdef DMA_TIMEOUT_EN
        input  o_error,
`endif
        output i_req, i_req_addr, i_req_count, i_dma_ready,
        input  o_grant, o_done, o_busy, o_dma_read, o_dma_address, o_dma_count
    );
endinterface

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter sharing one DMA engine among NUM_REQ requesters.
// Define DMA_TIMEOUT_EN to add a BUSY watchdog that ends the transfer with o_error.
module dma_rr_arbiter #(
    parameter int NUM_REQ           = 3,
    parameter int MEM_ADDRESS_WIDTH = 10,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input logic             clk,
    input logic             rst,
    dma_rr_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int W     = MEM_ADDRESS_WIDTH;

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg;
    logic [IDX_W-1:0]   grant_idx_reg;
    logic [IDX_W-1:0]   last_grant_reg;
    logic [W-1:0]       address_reg;
    logic [W-1:0]       count_reg;
    logic [W-1:0]       addr_arr  [NUM_REQ];
    logic [W-1:0]       count_arr [NUM_REQ];
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               dma_timeout;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.i_req_addr[gi*W +: W];
            assign count_arr[gi] = bus.i_req_count[gi*W +: W];
        end
    endgenerate

`ifdef DMA_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             timed_out_reg;
    assign dma_timeout = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign dma_timeout = 1'b0;
`endif

    // Search starts just past the last owner and wraps, so the previous winner is tried last.
    always_comb begin : arb_comb
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        win_valid = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            sum = {1'b0, last_grant_reg} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!win_valid && bus.i_req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (win_valid) begin
                    state_next = (count_arr[win_idx] == '0) ? DONE : LAUNCH;
                end
            end
            LAUNCH: state_next = BUSY;
            BUSY: begin
                if (bus.i_dma_ready || dma_timeout) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            grant_idx_reg  <= '0;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            address_reg    <= '0;
            count_reg      <= '0;
`ifdef DMA_TIMEOUT_EN
            wait_cnt_reg   <= '0;
            timed_out_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        grant_reg     <= NUM_REQ'(1) << win_idx;
                        grant_idx_reg <= win_idx;
                        address_reg   <= addr_arr[win_idx];
                        count_reg     <= count_arr[win_idx];
`ifdef DMA_TIMEOUT_EN
                        timed_out_reg <= 1'b0;
`endif
                    end
                end
`ifdef DMA_TIMEOUT_EN
                LAUNCH: wait_cnt_reg <= '0;
                BUSY: begin
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    if (!bus.i_dma_ready && dma_timeout) begin
                        timed_out_reg <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    last_grant_reg <= grant_idx_reg;
                    grant_reg      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_grant       = grant_reg;
    assign bus.o_done        = (state_reg == DONE) ? grant_reg : '0;
    assign bus.o_busy        = (state_reg != IDLE);
    assign bus.o_dma_read    = (state_reg == LAUNCH);
    assign bus.o_dma_address = address_reg;
    assign bus.o_dma_count   = count_reg;
`ifdef DMA_TIMEOUT_EN
    assign bus.o_error       = (state_reg == DONE) && timed_out_reg;
`endif
endmodule

// File: tb/tb_dma_rr_arbiter.sv
// Randomized bench for dma_rr_arbiter against a transaction-level round-robin model.
// Build with DMA_TIMEOUT_EN defined to also exercise the 16-cycle watchdog.
module tb_dma_rr_arbiter;
    localparam int N  = 3;
    localparam int W  = 10;
    localparam int TO = 16;
`ifdef DMA_TIMEOUT_EN
    localparam int MAX_DELAY = 12;
`else
    localparam int MAX_DELAY = 40;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_rr_arbiter_if #(.NUM_REQ(N), .MEM_ADDRESS_WIDTH(W)) bus();

    dma_rr_arbiter #(
        .NUM_REQ(N), .MEM_ADDRESS_WIDTH(W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [N-1:0] req_v;
    logic [W-1:0] addr_a [N];
    logic [W-1:0] cnt_a  [N];
    int           model_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Next owner: first pending requester after the previous owner, modulo N.
    function automatic int model_winner();
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (model_last + k) % N;
            if (req_v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive();
        bus.i_req = req_v;
        for (int i = 0; i < N; i++) begin
            bus.i_req_addr[i*W +: W]  = addr_a[i];
            bus.i_req_count[i*W +: W] = cnt_a[i];
        end
    endtask

    task automatic set_fields(input int i, input bit allow_zero);
        addr_a[i] = W'($urandom);
        if (allow_zero && $urandom_range(0, 3) == 0) cnt_a[i] = '0;
        else cnt_a[i] = W'($urandom_range(1, 1023));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_v = '0;
        bus.i_dma_ready = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(bus.o_grant), 32'(0));
        check("rst_done",  32'(bus.o_done), 32'(0));
        check("rst_busy",  32'(bus.o_busy), 32'(0));
        check("rst_read",  32'(bus.o_dma_read), 32'(0));
        check("rst_addr",  32'(bus.o_dma_address), 32'(0));
        check("rst_count", 32'(bus.o_dma_count), 32'(0));
`ifdef DMA_TIMEOUT_EN
        check("rst_error", 32'(bus.o_error), 32'(0));
`endif
        rst = 1'b0;
        model_last = N - 1;
    endtask

    // Called at a negedge with the DUT idle and req_v already driven.
    // mode 0: drop request at done, 1: keep requesting, 2: drop right after grant.
    task automatic serve(input int delay, input int mode, input bit stray);
        int w;
        logic [N-1:0] oh;
        logic [W-1:0] ea, ec;
        logic early;
        w = model_winner();
        if (w < 0) return;
        oh = '0;
        oh[w] = 1'b1;
        ea = addr_a[w];
        ec = cnt_a[w];
        txn++;
        $display("txn %0d: grant=%0d addr=0x%03h count=%0d delay=%0d mode=%0d",
                 txn, w, ea, ec, delay, mode);
        @(negedge clk);
        check("grant", 32'(bus.o_grant), 32'(oh));
        check("busy", 32'(bus.o_busy), 32'(1));
        if (ec == '0) begin
            check("zero_no_read", 32'(bus.o_dma_read), 32'(0));
            check("zero_done", 32'(bus.o_done), 32'(oh));
`ifdef DMA_TIMEOUT_EN
            check("zero_error", 32'(bus.o_error), 32'(0));
`endif
            if (mode == 1) set_fields(w, 1'b1);
        end else begin
            check("launch_read", 32'(bus.o_dma_read), 32'(1));
            check("launch_addr", 32'(bus.o_dma_address), 32'(ea));
            check("launch_count", 32'(bus.o_dma_count), 32'(ec));
            check("launch_no_done", 32'(bus.o_done), 32'(0));
            if (mode == 2) req_v[w] = 1'b0;
            set_fields(w, 1'b0);
            drive();
            if (stray) bus.i_dma_ready = 1'b1;
            @(negedge clk);
            bus.i_dma_ready = 1'b0;
            check("read_once", 32'(bus.o_dma_read), 32'(0));
            check("busy_wait", 32'(bus.o_busy), 32'(1));
            early = (bus.o_done != '0);
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                if (bus.o_done != '0 || bus.o_dma_read) early = 1'b1;
            end
            check("no_early_done", 32'(early), 32'(0));
            bus.i_dma_ready = 1'b1;
            @(negedge clk);
            bus.i_dma_ready = 1'b0;
            check("done", 32'(bus.o_done), 32'(oh));
            check("done_grant", 32'(bus.o_grant), 32'(oh));
            check("hold_addr", 32'(bus.o_dma_address), 32'(ea));
            check("hold_count", 32'(bus.o_dma_count), 32'(ec));
`ifdef DMA_TIMEOUT_EN
            check("done_error", 32'(bus.o_error), 32'(0));
`endif
        end
        model_last = w;
        if (mode != 1) req_v[w] = 1'b0;
        drive();
        @(negedge clk);
        check("idle_busy", 32'(bus.o_busy), 32'(0));
        check("idle_grant", 32'(bus.o_grant), 32'(0));
        check("idle_done", 32'(bus.o_done), 32'(0));
    endtask

    initial begin
        logic [N-1:0] fresh;
        logic early;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = '0;
            cnt_a[i]  = '0;
        end
        model_last = N - 1;
        do_reset();

        // Single request, ready 120 cycles after the launch pulse.
        req_v = 3'b001;
        addr_a[0] = 10'h010;
        cnt_a[0]  = 10'd120;
        drive();
`ifdef DMA_TIMEOUT_EN
        serve(10, 0, 1'b0);
`else
        serve(119, 0, 1'b0);
`endif

        // All three at once from reset: 0, 1, 2.
        do_reset();
        req_v = 3'b111;
        for (int i = 0; i < N; i++) set_fields(i, 1'b0);
        drive();
        serve(3, 0, 1'b1);
        serve(0, 0, 1'b0);
        serve(5, 0, 1'b1);

        // Requester 0 re-requests at its done while 2 waits: 0, 2, 0.
        req_v = 3'b101;
        set_fields(0, 1'b0);
        set_fields(2, 1'b0);
        drive();
        serve(2, 1, 1'b0);
        serve(2, 0, 1'b0);
        serve(2, 0, 1'b0);

        // Zero count skips the DMA launch.
        req_v = 3'b010;
        addr_a[1] = 10'h155;
        cnt_a[1]  = '0;
        drive();
        serve(0, 0, 1'b0);

        for (int r = 0; r < 60; r++) begin
            fresh = N'($urandom) & ~req_v;
            if ((req_v | fresh) == '0) fresh[$urandom_range(0, N-1)] = 1'b1;
            for (int i = 0; i < N; i++) if (fresh[i]) set_fields(i, 1'b1);
            req_v = req_v | fresh;
            drive();
            serve($urandom_range(0, MAX_DELAY), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Reset during BUSY abandons the transfer; a later ready is ignored.
        req_v = 3'b010;
        set_fields(1, 1'b0);
        drive();
        @(negedge clk);
        check("mid_launch", 32'(bus.o_dma_read), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(bus.o_busy), 32'(0));
        check("mid_rst_grant", 32'(bus.o_grant), 32'(0));
        check("mid_rst_addr", 32'(bus.o_dma_address), 32'(0));
        check("mid_rst_count", 32'(bus.o_dma_count), 32'(0));
        rst = 1'b0;
        model_last = N - 1;
        req_v = '0;
        drive();
        bus.i_dma_ready = 1'b1;
        @(negedge clk);
        bus.i_dma_ready = 1'b0;
        early = (bus.o_done != '0) || bus.o_busy;
        @(negedge clk);
        if (bus.o_done != '0 || bus.o_busy) early = 1'b1;
        check("stale_ready_ignored", 32'(early), 32'(0));
        req_v = 3'b100;
        set_fields(2, 1'b0);
        drive();
        serve(4, 0, 1'b0);

`ifdef DMA_TIMEOUT_EN
        // Ready never arrives: done and error together after 16 BUSY cycles.
        req_v = 3'b001;
        set_fields(0, 1'b0);
        drive();
        @(negedge clk);
        check("to_launch", 32'(bus.o_dma_read), 32'(1));
        @(negedge clk);
        early = (bus.o_done != '0) || bus.o_error;
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            if (bus.o_done != '0 || bus.o_error) early = 1'b1;
        end
        check("to_no_early", 32'(early), 32'(0));
        @(negedge clk);
        check("to_done", 32'(bus.o_done), 32'(3'b001));
        check("to_error", 32'(bus.o_error), 32'(1));
        model_last = 0;
        req_v = '0;
        drive();
        @(negedge clk);
        check("to_idle", 32'(bus.o_busy), 32'(0));
        check("to_error_clear", 32'(bus.o_error), 32'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
